// File: rtl/ieee2flopoco_4_10.sv
// Converts packed 1/4/10 binary operands to FloPoCo 17-bit {exc, sign, exp, frac}
// behind a 2-entry valid/ready elastic buffer. Optional macro: IEEE2FLOPOCO_FLUSH_COUNT_EN.
module ieee2flopoco_4_10 #(
  parameter int ID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef IEEE2FLOPOCO_FLUSH_COUNT_EN
  ,
  output logic [15:0] flush_count
`endif
);

  // ID is an instance tag only; this empty block just anchors it.
  if (ID == 0) begin : g_id_zero
  end

  // Handshake: a word moves on a rising edge only when valid and ready are both
  // high on the same side; valid never waits for ready, and in_ready depends on
  // registered state only, so out_ready has no combinational path to in_ready.
  logic [16:0] skid_data;
  logic        skid_valid;
  logic        in_fire;
  logic        out_fire;
  logic        out_load;
  logic        in_subnormal;

  function automatic logic [16:0] convert(input logic [14:0] d);
    logic       s;
    logic [3:0] e;
    logic [9:0] f;
    s = d[14];
    e = d[13:10];
    f = d[9:0];
    if (e == 4'd0)
      convert = {2'b00, s, 4'd0, 10'd0};
    else if (e == 4'hF && f == 10'd0)
      convert = {2'b10, s, 4'd0, 10'd0};
    else if (e == 4'hF)
      convert = {2'b11, s, e, f};
    else
      convert = {2'b01, s, e, f};
  endfunction

  assign in_ready     = ~skid_valid;
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid & out_ready;
  assign out_load     = out_fire | ~out_valid;
  assign in_subnormal = (in_data[13:10] == 4'd0) && (in_data[9:0] != 10'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= 17'd0;
      skid_valid <= 1'b0;
      skid_data  <= 17'd0;
    end else if (out_load) begin
      // Skid entry is always older than anything at the input, so it goes first.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_data  <= convert(in_data);
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_data  <= convert(in_data);
      skid_valid <= 1'b1;
    end
  end

`ifdef IEEE2FLOPOCO_FLUSH_COUNT_EN
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      flush_cnt_q <= 16'd0;
    else if (in_fire && in_subnormal && flush_cnt_q != 16'hFFFF)
      flush_cnt_q <= flush_cnt_q + 16'd1;
  end

  assign flush_count = flush_cnt_q;
`else
  logic unused_subnormal;
  assign unused_subnormal = in_subnormal;
`endif

endmodule

// File: doc/ieee2flopoco_4_10.md
IEEE2FLOPOCO_4_10 -- requirements
Module: ieee2flopoco_4_10

Purpose: upstream feeder stage for the fmul operand ports. It converts packed binary (1 sign, 4 exponent, 10 fraction, bias 7) into the FloPoCo 17-bit format: exc[16:15], sign[14], exp[13:10], frac[9:0]. It also provides a valid/ready elastic buffer.

Interface
REQ-001 Parameter: ID, default 1, instance tag with no functional effect.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  15  IEEE-style operand: sign[14], exp[13:10], frac[9:0].
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 out_data  output  17  FloPoCo operand for fmul X or Y.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  consumer takes out_data this cycle.
REQ-010 flush_count  output  16  count of subnormals flushed to zero; present only with the REQ-030 macro.

Function
REQ-011 A transfer occurs on a rising edge with valid&&ready high on the same side; there is no transfer otherwise.
REQ-012 Classification of accepted input, with E=exp and F=frac:
- E=0: exc=00 (zero), regardless of F.
- E=15, F=0: exc=10 (infinity).
- E=15, F!=0: exc=11 (NaN).
- Otherwise: exc=01 (normal).
REQ-013 Sign bit: copied unchanged in every class.
REQ-014 Normal class: out exp=E and out frac=F, unmodified; both formats use bias 7, so no exponent arithmetic is performed.
REQ-015 Zero and infinity classes: out exp and out frac forced to 0.
REQ-016 NaN class: out exp=E and out frac=F, payload preserved.
REQ-017 Subnormals (E=0, F!=0): flushed to signed zero (exc=00, sign kept, exp=0, frac=0).
REQ-018 Storage: a 2-entry elastic buffer, consisting of an output register plus one skid register.
REQ-019 Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
REQ-020 Throughput: 1 transfer per cycle sustained while out_ready=1.
REQ-021 in_ready SHALL equal NOT skid_valid, driven from a register; there is no combinational path from out_ready to in_ready.
REQ-022 out_ready=0 while out_valid=1:
- out_data SHALL be held stable.
- A new input SHALL be captured into the skid register.
REQ-023 When the skid register is full, in_ready=0 and no input is accepted.
REQ-024 On output transfer with the skid register full, the skid entry moves to the output register on the same edge.
REQ-025 Simultaneous input and output transfer with the skid register empty: the output register loads the new word; occupancy is unchanged.
REQ-026 Order SHALL be preserved; no word is dropped or duplicated.

Reset
REQ-027 On a rising edge with rst=1:
- out_valid=0, skid_valid=0, in_ready=1 from the next cycle;
- out_data=0;
- flush_count=0 (when present).
REQ-028 While rst=1, in_valid is ignored and no transfer is counted.
REQ-029 Reset asserted mid-stream discards both buffered words.

Configuration
REQ-030 Macro IEEE2FLOPOCO_FLUSH_COUNT_EN:
- Defined: port flush_count exists. It increments by 1 on each accepted subnormal input and saturates at 0xFFFF.
- Undefined: the port and the counter are absent. Conversion and handshake behaviour are identical in both cases.

Verification
REQ-031 Normal: 0x1C00 (1.0) with out_ready=1 -> out_data=0x09C00 one cycle later, out_valid=1.
REQ-032 Specials:
- 0x3C00 -> 0x10000 (+inf).
- 0x7C00 -> 0x14000 (-inf).
- 0x3C01 -> 0x1BC01 (NaN, payload kept).
- 0x4000 -> 0x04000 (-0).
REQ-033 Subnormal: 0x0001, then 0x43FF -> 0x00000, then 0x04000. With the macro defined, flush_count=2.
REQ-034 Backpressure:
- Stimulus: out_ready=0 for 3 cycles while A, B, C, D are offered back-to-back.
- Required: only A and B are accepted, and in_ready=0 from the cycle after B is accepted.
- On release: A, B, C, D emerge in order with no gaps.
REQ-035 Reset mid-stream: rst=1 for 1 cycle with both entries full -> out_valid=0 next cycle, and the next accepted word appears alone.
REQ-036 Saturation (macro defined): 65536 subnormal inputs -> flush_count=0xFFFF, and it stays there after a further subnormal input.
